// File: rtl/cache_definition.sv
// Shared types for the CPU-side cache interface, the request queue entry and
// the request queue issue FSM.
package cache_definition;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
        logic        rw;
        logic        valid;
    } cpu_to_cache_type;

    typedef struct packed {
        logic [31:0] data;
        logic        ready;
    } cache_to_cpu_type;

    typedef struct packed {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
    } cache_req_entry_type;

    typedef enum logic [1:0] {
        REQ_IDLE,
        REQ_BUSY,
        REQ_RESP
    } req_q_state_type;

endpackage

// File: rtl/cache_req_fifo.sv
// DEPTH-entry request FIFO: storage, wrapping pointers and occupancy count.
// The head entry is presented combinationally and leaves only on pop.
module cache_req_fifo
    import cache_definition::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  cache_req_entry_type push_entry,
    input  logic                pop,
    output logic                full,
    output logic                empty,
    output cache_req_entry_type head,
    output logic [PTR_W:0]      count
);

    cache_req_entry_type mem [DEPTH];
    logic [PTR_W-1:0]    wr_ptr;
    logic [PTR_W-1:0]    rd_ptr;

    // NOTE: storage has no reset; an entry is never read before it is written,
    // and leaving it out of the reset keeps it mappable to plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

endmodule

// File: rtl/cache_req_queue.sv
// CPU request queue in front of the cache: buffers requests, issues them one at
// a time and returns a one-cycle response. Define CACHE_REQ_QUEUE_STATS_EN for counters.
module cache_req_queue
    import cache_definition::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_rw,
    input  logic [31:0]      req_addr,
    input  logic [31:0]      req_data,
    output logic             rsp_valid,
    output logic             rsp_rw,
    output logic [31:0]      rsp_data,
    output logic [PTR_W:0]   occupancy,
    output cpu_to_cache_type cpu_to_cache,
    input  cache_to_cpu_type cache_to_cpu
`ifdef CACHE_REQ_QUEUE_STATS_EN
    ,
    output logic [31:0]      stat_reads,
    output logic [31:0]      stat_writes,
    output logic [31:0]      stat_stall_cycles
`endif
);

    req_q_state_type     state, state_n;
    cpu_to_cache_type    c2c_n;
    logic                rsp_valid_n, rsp_rw_n;
    logic [31:0]         rsp_data_n;
    logic                push, pop, full, empty;
    cache_req_entry_type head;

    assign req_ready = !full;
    assign push      = req_valid && req_ready;

    cache_req_fifo #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry ('{rw: req_rw, addr: req_addr, data: req_data}),
        .pop        (pop),
        .full       (full),
        .empty      (empty),
        .head       (head),
        .count      (occupancy)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= REQ_IDLE;
        else      state <= state_n;
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case can leave one unassigned and infer a latch.
    always_comb begin
        state_n     = state;
        c2c_n       = cpu_to_cache;
        rsp_valid_n = 1'b0;
        rsp_rw_n    = rsp_rw;
        rsp_data_n  = rsp_data;
        pop         = 1'b0;
        case (state)
            REQ_IDLE: begin
                if (!empty) begin
                    c2c_n   = '{addr: head.addr, data: head.data, rw: head.rw, valid: 1'b1};
                    state_n = REQ_BUSY;
                end
            end
            REQ_BUSY: begin
                if (cache_to_cpu.ready) begin
                    rsp_valid_n = 1'b1;
                    rsp_rw_n    = cpu_to_cache.rw;
                    rsp_data_n  = cpu_to_cache.rw ? 32'h0 : cache_to_cpu.data;
                    c2c_n.valid = 1'b0;
                    pop         = 1'b1;
                    state_n     = REQ_RESP;
                end
            end
            // One idle cycle guarantees valid drops between back-to-back requests.
            REQ_RESP: state_n = REQ_IDLE;
            default:  state_n = REQ_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_to_cache <= '0;
            rsp_valid    <= 1'b0;
            rsp_rw       <= 1'b0;
            rsp_data     <= '0;
        end else begin
            cpu_to_cache <= c2c_n;
            rsp_valid    <= rsp_valid_n;
            rsp_rw       <= rsp_rw_n;
            rsp_data     <= rsp_data_n;
        end
    end

`ifdef CACHE_REQ_QUEUE_STATS_EN
    logic stall_cycle;
    assign stall_cycle = (state == REQ_BUSY) && !cache_to_cpu.ready;

    // Counters saturate rather than wrap so long runs never read back small.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_reads        <= '0;
            stat_writes       <= '0;
            stat_stall_cycles <= '0;
        end else begin
            if (pop && !cpu_to_cache.rw && stat_reads != '1)  stat_reads  <= stat_reads + 1'b1;
            if (pop && cpu_to_cache.rw && stat_writes != '1)  stat_writes <= stat_writes + 1'b1;
            if (stall_cycle && stat_stall_cycles != '1)       stat_stall_cycles <= stat_stall_cycles + 1'b1;
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule
